cpu_clkgen: RTL and testbench

Parametrised clock-enable and wait-state generator for the Z80 core. It produces the complementary `cep`/`cen` phase enables from the system clock with a runtime-selectable divider and a freeze control. It also drives `wait_n` to insert a programmable number of wait states on memory and I/O accesses. It sits between the system clock domain and the CPU wrapper, replacing fixed enable generation and the constant-high WAIT tie-off.

---
 rtl/cpu_clkgen.sv | 107 ++++++++++
 tb/tb_cpu_clkgen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_clkgen.sv
// Z80 clock-enable generator: complementary cep/cen phase enables from the system
// clock with a runtime divider and freeze, plus WAIT_n insertion on memory/I/O accesses.
module cpu_clkgen #(
  parameter int DIV_W = 4,
  parameter int WS_W  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             hold,
  input  logic             mreq,
  input  logic             iorq,
  input  logic [WS_W-1:0]  ws_mem,
  input  logic [WS_W-1:0]  ws_io,
  output logic             cep,
  output logic             cen,
  output logic             wait_n
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             cep_q, cep_d;
  logic             cen_q, cen_d;
  logic [WS_W-1:0]  wcnt_q, wcnt_d;
  logic             mreq_q, mreq_d;
  logic             iorq_q, iorq_d;
  logic             wait_q, wait_d;
  logic             wrap_s;
  logic             io_start_s;
  logic             mem_start_s;

  // Divider: a wrap issues the enable of the current phase, then flips the phase.
  // After div is lowered below cnt, the counter simply runs on and wraps naturally.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    cep_d   = 1'b0;
    cen_d   = 1'b0;
    wrap_s  = (cnt_q == div);
    if (hold) begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end else if (wrap_s) begin
      cnt_d   = {DIV_W{1'b0}};
      phase_d = ~phase_q;
      cep_d   = ~phase_q;
      cen_d   = phase_q;
    end else begin
      cnt_d   = cnt_q + DIV_W'(1);
      phase_d = phase_q;
    end
  end

  // Wait-state counter: strobes are sampled in the cep cycle, decrements happen in
  // the cen cycle; the two never coincide so a load can never race a decrement.
  always_comb begin
    mreq_d      = mreq_q;
    iorq_d      = iorq_q;
    wcnt_d      = wcnt_q;
    io_start_s  = iorq_q & ~iorq;
    mem_start_s = mreq_q & ~mreq;
    if (cep_q) begin
      mreq_d = mreq;
      iorq_d = iorq;
      if (io_start_s) begin
        wcnt_d = ws_io;
      end else if (mem_start_s) begin
        wcnt_d = ws_mem;
      end else begin
        wcnt_d = wcnt_q;
      end
    end else if (cen_q && (wcnt_q != {WS_W{1'b0}})) begin
      wcnt_d = wcnt_q - WS_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
    wait_d = (wcnt_d == {WS_W{1'b0}});
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= {DIV_W{1'b0}};
      phase_q <= 1'b0;
      cep_q   <= 1'b0;
      cen_q   <= 1'b0;
      wcnt_q  <= {WS_W{1'b0}};
      mreq_q  <= 1'b1;
      iorq_q  <= 1'b1;
      wait_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      cep_q   <= cep_d;
      cen_q   <= cen_d;
      wcnt_q  <= wcnt_d;
      mreq_q  <= mreq_d;
      iorq_q  <= iorq_d;
      wait_q  <= wait_d;
    end
  end

  assign cep    = cep_q;
  assign cen    = cen_q;
  assign wait_n = wait_q;

endmodule

// File: tb/tb_cpu_clkgen.sv
// Directed bench for cpu_clkgen: enable traces are packed per clock edge
// (bit k = value sampled just after the (k+1)th edge of the trace) and compared.
module tb_cpu_clkgen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] div   = 4'd1;
  logic       hold  = 1'b0;
  logic       mreq  = 1'b1;
  logic       iorq  = 1'b1;
  logic [2:0] ws_mem = 3'd0;
  logic [2:0] ws_io  = 3'd0;
  logic       cep, cen, wait_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] tr_cep, tr_cen, tr_wl;
  int          tr_n;

  cpu_clkgen #(.DIV_W(4), .WS_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .div   (div),
    .hold  (hold),
    .mreq  (mreq),
    .iorq  (iorq),
    .ws_mem(ws_mem),
    .ws_io (ws_io),
    .cep   (cep),
    .cen   (cen),
    .wait_n(wait_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic trace_clear();
    tr_cep = 64'd0;
    tr_cen = 64'd0;
    tr_wl  = 64'd0;
    tr_n   = 0;
  endtask

  task automatic run_trace(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      tr_cep[tr_n] = cep;
      tr_cen[tr_n] = cen;
      tr_wl[tr_n]  = ~wait_n;
      tr_n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int popcnt(input logic [63:0] v);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_cep", {63'd0, cep}, 64'd0);
    chk("rst_cen", {63'd0, cen}, 64'd0);
    chk("rst_wait_n", {63'd0, wait_n}, 64'd1);

    // div=1 from reset release
    reset = 1'b0;
    trace_clear();
    run_trace(8);
    chk("div1_cep", tr_cep, 64'h22);
    chk("div1_cen", tr_cen, 64'h88);
    chk("div1_overlap", tr_cep & tr_cen, 64'h0);

    // div=0 then div=3
    div = 4'd0;
    trace_clear();
    run_trace(8);
    chk("div0_cep", tr_cep, 64'h55);
    chk("div0_cen", tr_cen, 64'hAA);
    div = 4'd3;
    trace_clear();
    run_trace(16);
    chk("div3_cep", tr_cep, 64'h0808);
    chk("div3_cen", tr_cen, 64'h8080);

    // div=2 with hold mid-phase
    div = 4'd2;
    tick();
    hold = 1'b1;
    trace_clear();
    run_trace(10);
    chk("hold_quiet", tr_cep | tr_cen, 64'h0);
    hold = 1'b0;
    trace_clear();
    run_trace(8);
    chk("hold_rel_cep", tr_cep, 64'h82);
    chk("hold_rel_cen", tr_cen, 64'h10);

    // memory access, 2 wait states
    div = 4'd2;
    ws_mem = 3'd2;
    ws_io  = 3'd0;
    mreq = 1'b0;
    do_reset();
    trace_clear();
    run_trace(14);
    chk("mem2_wait", tr_wl, 64'h0FF8);
    chk("mem2_cen_in_wait", 64'(popcnt(tr_cen & tr_wl)), 64'd2);
    mreq = 1'b1;

    // simultaneous I/O and memory start: I/O wins
    ws_mem = 3'd1;
    ws_io  = 3'd3;
    mreq = 1'b0;
    iorq = 1'b0;
    do_reset();
    trace_clear();
    run_trace(20);
    chk("io_prio_wait", tr_wl, 64'h3FFF8);
    chk("io_prio_cen_in_wait", 64'(popcnt(tr_cen & tr_wl)), 64'd3);

    // zero-wait I/O still wins over a nonzero memory setting
    ws_mem = 3'd5;
    ws_io  = 3'd0;
    do_reset();
    trace_clear();
    run_trace(20);
    chk("io_zero_wait", tr_wl, 64'h0);
    mreq = 1'b1;
    iorq = 1'b1;

    // hold while waiting freezes the wait count
    div = 4'd1;
    ws_mem = 3'd2;
    mreq = 1'b0;
    do_reset();
    trace_clear();
    run_trace(4);
    hold = 1'b1;
    run_trace(6);
    hold = 1'b0;
    run_trace(8);
    chk("hold_wait", tr_wl, 64'h3FFC);
    chk("hold_wait_cep", tr_cep, 64'h8802);
    chk("hold_wait_cen", tr_cen, 64'h22008);
    mreq = 1'b1;

    // asynchronous reset in the middle of a long wait
    div = 4'd2;
    ws_mem = 3'd7;
    mreq = 1'b0;
    do_reset();
    trace_clear();
    run_trace(9);
    chk("pre_rst_cep", {63'd0, cep}, 64'd1);
    chk("pre_rst_wait_n", {63'd0, wait_n}, 64'd0);
    reset = 1'b1;
    #2;
    chk("async_rst_cep", {63'd0, cep}, 64'd0);
    chk("async_rst_cen", {63'd0, cen}, 64'd0);
    chk("async_rst_wait_n", {63'd0, wait_n}, 64'd1);
    mreq = 1'b1;
    tick();
    reset = 1'b0;
    trace_clear();
    run_trace(4);
    chk("post_rst_cep", tr_cep, 64'h4);
    chk("post_rst_cen", tr_cen, 64'h0);
    chk("post_rst_wait", tr_wl, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
